// File: rtl/mul_pkg.sv
// Shared definitions for the parametrised sequential multiplier.
//   state_t      : controller states (IDLE -> CALC -> FIN -> IDLE)
//   width_cfg_ok : elaboration-time legality check for WIDTH/BPC pairs
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  // A configuration is legal when the operand is at least two bits wide and
  // the per-cycle digit width divides it exactly.
  function automatic bit width_cfg_ok(input int width, input int bpc);
    return (width >= 2) && (bpc >= 1) && (bpc <= width) && ((width % bpc) == 0);
  endfunction

endpackage

// File: rtl/mul_seq_param_if.sv
// Start/busy handshake bundle between a controller and mul_seq_param.
//   a_bi, b_bi : multiplicand / multiplier (WIDTH bits)
//   signed_i   : 1 = two's-complement operation, sampled with start_i
//   start_i    : operation request
//   busy_o     : operation in flight
//   done_o     : one-cycle strobe when y_bo updates
//   y_bo       : 2*WIDTH product, holds the last result
interface mul_seq_param_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0]   a_bi;
  logic [WIDTH-1:0]   b_bi;
  logic               signed_i;
  logic               start_i;
  logic               busy_o;
  logic               done_o;
  logic [2*WIDTH-1:0] y_bo;

  modport master (
    output a_bi, b_bi, signed_i, start_i,
    input  busy_o, done_o, y_bo
  );

  modport slave (
    input  a_bi, b_bi, signed_i, start_i,
    output busy_o, done_o, y_bo
  );
endinterface

// File: rtl/mul_pp_row.sv
// Combinational WIDTH x BPC partial-product generator.
//   mcand_i : unsigned multiplicand magnitude (WIDTH bits)
//   digit_i : current multiplier digit (BPC bits)
//   pp_o    : mcand_i * digit_i, exact (WIDTH+BPC bits)
module mul_pp_row #(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic [WIDTH-1:0]     mcand_i,
  input  logic [BPC-1:0]       digit_i,
  output logic [WIDTH+BPC-1:0] pp_o
);

  // Both operands are widened to the result width so the product is exact.
  assign pp_o = (WIDTH+BPC)'(mcand_i) * (WIDTH+BPC)'(digit_i);

endmodule

// File: rtl/mul_seq_param.sv
// Parametrised iterative shift-add multiplier, BPC multiplier bits per cycle.
// Operands are reduced to magnitudes on capture; the sign is reapplied in FIN.
//   clk_i : clock, rising edge
//   rst_i : asynchronous reset, active-low
//   bus   : slave side of mul_seq_param_if (operands, mode, start/busy/done, y)
module mul_seq_param
  import mul_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  mul_seq_param_if.slave  bus
);

  localparam int ITER = WIDTH / BPC;
  localparam int KW   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int W2   = 2 * WIDTH;

  generate
    if (!width_cfg_ok(WIDTH, BPC)) begin : g_bad_cfg
      $error("mul_seq_param: BPC must divide WIDTH and WIDTH must be >= 2");
    end
  endgenerate

  // Magnitude of an operand; in signed mode -2^(WIDTH-1) maps to 2^(WIDTH-1),
  // which is still representable as a WIDTH-bit unsigned value.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  mcand_q;
  logic [WIDTH-1:0]  mplier_q;
  logic              neg_q;
  logic [KW-1:0]     k_q;
  logic [W2-1:0]     acc_q;
  logic [W2-1:0]     y_q;
  logic              done_q;
  logic              busy;

  logic [WIDTH+BPC-1:0] pp;
  logic [W2-1:0]        pp_ext;
  logic [W2-1:0]        pp_shf;
  int unsigned          shamt;

  mul_pp_row #(
    .WIDTH (WIDTH),
    .BPC   (BPC)
  ) u_pp_row (
    .mcand_i (mcand_q),
    .digit_i (mplier_q[BPC-1:0]),
    .pp_o    (pp)
  );

  // Align the current digit's partial product to its weight BPC*k.
  always_comb begin
    pp_ext = '0;
    pp_ext[WIDTH+BPC-1:0] = pp;
    shamt  = BPC * int'(k_q);
    pp_shf = pp_ext << shamt;
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start_i) state_d = CALC;
      CALC:    if (k_q == KW'(ITER - 1)) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q != IDLE);
  end

  // Datapath: capture, accumulate, sign-fix and publish
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      k_q      <= '0;
      acc_q    <= '0;
      y_q      <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            mcand_q  <= mag(bus.a_bi, bus.signed_i);
            mplier_q <= mag(bus.b_bi, bus.signed_i);
            neg_q    <= bus.signed_i & (bus.a_bi[WIDTH-1] ^ bus.b_bi[WIDTH-1]);
            acc_q    <= '0;
            k_q      <= '0;
          end
        end
        CALC: begin
          acc_q    <= acc_q + pp_shf;
          mplier_q <= mplier_q >> BPC;
          k_q      <= k_q + 1'b1;
        end
        FIN: begin
          y_q    <= neg_q ? (~acc_q + 1'b1) : acc_q;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_o = busy;
  assign bus.done_o = done_q;
  assign bus.y_bo   = y_q;

endmodule
